// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, constants and GF(2^8) helpers
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// rtl/aes_key_round.sv - one AES-128 key-expansion round: prev key and rcon to next key
module aes_key_round (
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0  = prev_key[127:96];
    assign w1  = prev_key[95:64];
    assign w2  = prev_key[63:32];
    assign w3  = prev_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .s (sub[8*i +: 8])
        );
    end

    assign temp = sub ^ {rcon, 24'h000000};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box (inverse plus affine map)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key schedule with round-key store and read port
module aes_key_sched_ctrl
    import aes_pkg::state_e, aes_pkg::IDLE, aes_pkg::EXPAND, aes_pkg::READY,
           aes_pkg::RCON_INIT, aes_pkg::xtime;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST = 4'(NR);

    state_e       state;
    state_e       state_next;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] rk [0:NR];
    logic         accept;
    logic         step;
    logic [127:0] prev_key;
    logic [127:0] next_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                accept    = key_valid;
                if (key_valid) state_next = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) state_next = READY;
            end
            READY: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
                accept     = key_valid;
                if (key_valid) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt is at least 1 whenever step is asserted, so cnt-1 stays in range.
    assign prev_key = rk[cnt - 4'd1];

    aes_key_round u_round (
        .prev_key (prev_key),
        .rcon     (rcon),
        .next_key (next_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            rcon <= RCON_INIT;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else if (accept) begin
            rk[0] <= key_in;
            cnt   <= 4'd1;
            rcon  <= RCON_INIT;
        end else if (step) begin
            rk[cnt] <= next_key;
            rcon    <= xtime(rcon);
            if (cnt != LAST) cnt <= cnt + 4'd1;
        end
    end

    // Registered read; sees rk before any same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rd_key <= '0;
        else if (rd_idx <= LAST) rd_key <= rk[rd_idx];
        else                     rd_key <= '0;
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    // Called at a negedge: offers key for one cycle, returns negedges until keys_valid (40 = timeout).
    task automatic expand(input logic [127:0] key, output int cycles);
        key_in    = key;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        cycles    = 1;
        while (!keys_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        #1;
        n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_keys_valid: got %b expected 0", keys_valid); end
        n_vec++; if (rd_key !== 128'h0) begin n_err++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_expand;
        int cyc;
        expand(FIPS_KEY, cyc);
        n_vec++; if (cyc !== NR + 1) begin n_err++; $display("FAIL fips_latency: got %0d expected %0d", cyc, NR + 1); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fips_busy_done: got %b expected 0", busy); end
    endtask

    task automatic test_rd_sweep;
        logic [127:0] exp;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            @(negedge clk);
            if (i <= NR) exp = FIPS_RK[i];
            else         exp = 128'h0;
            n_vec++;
            if (rd_key !== exp) begin n_err++; $display("FAIL sweep_idx%0d: got %h expected %h", i, rd_key, exp); end
        end
    endtask

    task automatic test_key_hold;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        for (int k = 1; k < NR; k++) begin
            @(negedge clk);
            n_vec++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL hold_key_ready_c%0d: got %b expected 0", k, key_ready); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy_c%0d: got %b expected 1", k, busy); end
            key_in = KEY2;
        end
        key_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL hold_early_valid: got %b expected 0", keys_valid); end
        @(negedge clk);
        n_vec++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL hold_keys_valid: got %b expected 1", keys_valid); end
        rd_idx = 4'd1;
        @(negedge clk);
        n_vec++; if (rd_key !== FIPS_RK[1]) begin n_err++; $display("FAIL hold_rk1: got %h expected %h", rd_key, FIPS_RK[1]); end
        rd_idx = 4'd10;
        @(negedge clk);
        n_vec++; if (rd_key !== FIPS_RK[10]) begin n_err++; $display("FAIL hold_rk10: got %h expected %h", rd_key, FIPS_RK[10]); end
    endtask

    task automatic test_rekey_zero;
        int cyc;
        key_in    = 128'h0;
        key_valid = 1'b1;
        n_vec++; if (keys_valid !== 1'b1) begin n_err++; $display("FAIL rekey_pre_valid: got %b expected 1", keys_valid); end
        @(negedge clk);
        key_valid = 1'b0;
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL rekey_valid_drop: got %b expected 0", keys_valid); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rekey_busy: got %b expected 1", busy); end
        cyc = 1;
        while (!keys_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++; if (cyc !== NR + 1) begin n_err++; $display("FAIL rekey_latency: got %0d expected %0d", cyc, NR + 1); end
        rd_idx = 4'd10;
        @(negedge clk);
        n_vec++; if (rd_key !== ZERO_RK10) begin n_err++; $display("FAIL rekey_rk10: got %h expected %h", rd_key, ZERO_RK10); end
        rd_idx = 4'd1;
        @(negedge clk);
        n_vec++; if (rd_key !== ZERO_RK1) begin n_err++; $display("FAIL rekey_rk1: got %h expected %h", rd_key, ZERO_RK1); end
    endtask

    task automatic test_reset_mid_expand;
        int cyc;
        bit seen_valid;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL midrst_key_ready: got %b expected 1", key_ready); end
        n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL midrst_keys_valid: got %b expected 0", keys_valid); end
        n_vec++; if (rd_key !== 128'h0) begin n_err++; $display("FAIL midrst_rd_key: got %h expected 0", rd_key); end
        @(negedge clk);
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (keys_valid !== 1'b0) seen_valid = 1'b1;
        end
        n_vec++; if (seen_valid) begin n_err++; $display("FAIL midrst_stays_invalid: got 1 expected 0"); end
        n_vec++; if (rd_key !== 128'h0) begin n_err++; $display("FAIL midrst_rk_cleared: got %h expected 0", rd_key); end
        expand(FIPS_KEY, cyc);
        n_vec++; if (cyc !== NR + 1) begin n_err++; $display("FAIL midrst_relatency: got %0d expected %0d", cyc, NR + 1); end
        rd_idx = 4'd10;
        @(negedge clk);
        n_vec++; if (rd_key !== FIPS_RK[10]) begin n_err++; $display("FAIL midrst_rk10: got %h expected %h", rd_key, FIPS_RK[10]); end
    endtask

    task automatic test_read_during_accept;
        int cyc;
        rd_idx    = 4'd0;
        key_in    = 128'h0;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        n_vec++; if (rd_key !== FIPS_RK[0]) begin n_err++; $display("FAIL acc_read_old_rk0: got %h expected %h", rd_key, FIPS_RK[0]); end
        @(negedge clk);
        n_vec++; if (rd_key !== 128'h0) begin n_err++; $display("FAIL acc_read_new_rk0: got %h expected 0", rd_key); end
        cyc = 2;
        while (!keys_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++; if (cyc !== NR + 1) begin n_err++; $display("FAIL acc_latency: got %0d expected %0d", cyc, NR + 1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips_expand();
        test_rd_sweep();
        test_key_hold();
        test_rekey_zero();
        test_reset_mid_expand();
        test_read_during_accept();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
